ecc_mult_arbiter: RTL and testbench

- Shares one Montgomery-ladder scalar-multiplication engine between NUM_REQ requesters (e.g. ECDH keygen, ECDSA sign).
- Grants requesters round-robin and latches the granted requester's operands so they stay stable for the whole engine run.
- Sequences the engine's level-sensitive go/done handshake and returns the result to the winner.
- A watchdog aborts hung operations by pulsing the engine reset.

---
 rtl/ecc_pkg.sv | 5 +
 rtl/rr_pick.sv | 28 ++
 rtl/ecc_mult_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_ecc_mult_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
// ecc_pkg: arbiter state encoding and engine-abort reset length shared by ECC engine arbiters
package ecc_pkg;
  typedef enum logic [2:0] {IDLE, START, RESP, DRAIN, ABORT} state_t;
  localparam int ABORT_RST_CYCLES = 2;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: round-robin priority picker; in req, ptr (first slot scanned); out onehot, idx, found
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          found
);
  logic [IW-1:0] k;
  always_comb begin
    onehot = '0;
    idx = '0;
    found = 1'b0;
    k = '0;
    for (int i = N - 1; i >= 0; i--) begin
      k = IW'((int'(ptr) + i) % N);
      if (req[k]) begin
        onehot = '0;
        onehot[k] = 1'b1;
        idx = k;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/ecc_mult_arbiter.sv
// ecc_mult_arbiter: round-robin share of one ladder engine; req/m_in/px_in/py_in/curve in, grant/busy/resp_* out, eng_* drive and read the engine
module ecc_mult_arbiter
  import ecc_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int key_size       = 256,
  parameter int integer_size   = 64,
  parameter int TIMEOUT_CYCLES = 2**20,
  parameter int DRAIN_CYCLES   = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*key_size-1:0]     m_in,
  input  logic [NUM_REQ*integer_size-1:0] px_in,
  input  logic [NUM_REQ*integer_size-1:0] py_in,
  input  logic [integer_size-1:0]         prime,
  input  logic [integer_size-1:0]         A,
  input  logic [integer_size-1:0]         B,
  output logic [NUM_REQ-1:0]              grant,
  output logic                            busy,
  output logic [NUM_REQ-1:0]              resp_valid,
  output logic [integer_size-1:0]         resp_x,
  output logic [integer_size-1:0]         resp_y,
  output logic                            resp_inf,
  output logic                            resp_err,
  output logic                            eng_rst,
  output logic                            eng_go,
  output logic [key_size-1:0]             eng_m,
  output logic [integer_size-1:0]         eng_prime,
  output logic [integer_size-1:0]         eng_A,
  output logic [integer_size-1:0]         eng_B,
  output logic [integer_size-1:0]         eng_Px,
  output logic [integer_size-1:0]         eng_Py,
  output logic [integer_size-1:0]         eng_Ox,
  output logic [integer_size-1:0]         eng_Oy,
  input  logic                            eng_done,
  input  logic                            eng_inf,
  input  logic [key_size-1:0]             eng_mGx,
  input  logic [key_size-1:0]             eng_mGy
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES + DRAIN_CYCLES + ABORT_RST_CYCLES) + 1;
  localparam int DR = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES : 1;
  state_t state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d, resp_valid_q, resp_valid_d, pick_oh;
  logic [IW-1:0] gidx_q, gidx_d, rr_ptr_q, rr_ptr_d, pick_idx, next_ptr;
  logic [CW-1:0] wd_q, wd_d;
  logic [integer_size-1:0] resp_x_q, resp_x_d, resp_y_q, resp_y_d;
  logic resp_inf_q, resp_inf_d, resp_err_q, resp_err_d, eng_rst_q, eng_rst_d, eng_go_q, eng_go_d;
  logic [key_size-1:0] eng_m_q, eng_m_d;
  logic [integer_size-1:0] eng_prime_q, eng_prime_d, eng_a_q, eng_a_d, eng_b_q, eng_b_d;
  logic [integer_size-1:0] eng_px_q, eng_px_d, eng_py_q, eng_py_d;
  logic pick_found;
  // The engine returns key_size-wide coordinates; only the field-width low part is meaningful.
  logic unused_hi;
  assign unused_hi = ^{eng_mGx, eng_mGy};
  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req(req), .ptr(rr_ptr_q), .onehot(pick_oh), .idx(pick_idx), .found(pick_found)
  );
  assign next_ptr = (gidx_q == IW'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d = gidx_q;
    rr_ptr_d = rr_ptr_q;
    wd_d = wd_q;
    resp_valid_d = '0;
    resp_x_d = resp_x_q;
    resp_y_d = resp_y_q;
    resp_inf_d = resp_inf_q;
    resp_err_d = resp_err_q;
    eng_rst_d = eng_rst_q;
    eng_go_d = eng_go_q;
    eng_m_d = eng_m_q;
    eng_prime_d = eng_prime_q;
    eng_a_d = eng_a_q;
    eng_b_d = eng_b_q;
    eng_px_d = eng_px_q;
    eng_py_d = eng_py_q;
    case (state_q)
      IDLE: if (pick_found) begin
        grant_d = pick_oh;
        gidx_d = pick_idx;
        eng_m_d = m_in[pick_idx*key_size +: key_size];
        eng_px_d = px_in[pick_idx*integer_size +: integer_size];
        eng_py_d = py_in[pick_idx*integer_size +: integer_size];
        eng_prime_d = prime;
        eng_a_d = A;
        eng_b_d = B;
        eng_go_d = 1'b1;
        wd_d = '0;
        state_d = START;
      end
      START: begin
        wd_d = wd_q + 1'b1;
        if (eng_done) begin
          resp_x_d = eng_mGx[integer_size-1:0];
          resp_y_d = eng_mGy[integer_size-1:0];
          resp_inf_d = eng_inf;
          resp_err_d = 1'b0;
          state_d = RESP;
        end else if (wd_q == CW'(TIMEOUT_CYCLES - 1)) begin
          // go falls on the same edge rst rises, so the two are never high together
          eng_go_d = 1'b0;
          eng_rst_d = 1'b1;
          wd_d = '0;
          state_d = ABORT;
        end
      end
      RESP: begin
        resp_valid_d = grant_q;
        grant_d = '0;
        eng_go_d = 1'b0;
        rr_ptr_d = next_ptr;
        wd_d = '0;
        state_d = DRAIN;
      end
      DRAIN: begin
        wd_d = wd_q + 1'b1;
        if (wd_q == CW'(DR - 1)) state_d = IDLE;
      end
      ABORT: begin
        wd_d = wd_q + 1'b1;
        if (wd_q == CW'(ABORT_RST_CYCLES - 1)) begin
          eng_rst_d = 1'b0;
          resp_valid_d = grant_q;
          resp_err_d = 1'b1;
          resp_x_d = '0;
          resp_y_d = '0;
          resp_inf_d = 1'b0;
          grant_d = '0;
          rr_ptr_d = next_ptr;
          wd_d = '0;
          state_d = DRAIN;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q <= '0;
      rr_ptr_q <= '0;
      wd_q <= '0;
      resp_valid_q <= '0;
      resp_x_q <= '0;
      resp_y_q <= '0;
      resp_inf_q <= 1'b0;
      resp_err_q <= 1'b0;
      eng_rst_q <= 1'b0;
      eng_go_q <= 1'b0;
      eng_m_q <= '0;
      eng_prime_q <= '0;
      eng_a_q <= '0;
      eng_b_q <= '0;
      eng_px_q <= '0;
      eng_py_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q <= gidx_d;
      rr_ptr_q <= rr_ptr_d;
      wd_q <= wd_d;
      resp_valid_q <= resp_valid_d;
      resp_x_q <= resp_x_d;
      resp_y_q <= resp_y_d;
      resp_inf_q <= resp_inf_d;
      resp_err_q <= resp_err_d;
      eng_rst_q <= eng_rst_d;
      eng_go_q <= eng_go_d;
      eng_m_q <= eng_m_d;
      eng_prime_q <= eng_prime_d;
      eng_a_q <= eng_a_d;
      eng_b_q <= eng_b_d;
      eng_px_q <= eng_px_d;
      eng_py_q <= eng_py_d;
    end
  end
  assign grant = grant_q;
  assign busy = state_q != IDLE;
  assign resp_valid = resp_valid_q;
  assign resp_x = resp_x_q;
  assign resp_y = resp_y_q;
  assign resp_inf = resp_inf_q;
  assign resp_err = resp_err_q;
  assign eng_rst = eng_rst_q;
  assign eng_go = eng_go_q;
  assign eng_m = eng_m_q;
  assign eng_prime = eng_prime_q;
  assign eng_A = eng_a_q;
  assign eng_B = eng_b_q;
  assign eng_Px = eng_px_q;
  assign eng_Py = eng_py_q;
  assign eng_Ox = '0;
  assign eng_Oy = '0;
endmodule

// File: tb/tb_ecc_mult_arbiter.sv
// tb_ecc_mult_arbiter: directed checks of the arbiter against a behavioural curve-arithmetic engine
module tb_ecc_mult_arbiter;
  localparam int LAT = 5;
  logic clk = 1'b0, rst = 1'b0, hang = 1'b0;
  logic [1:0] req = '0, grant, resp_valid;
  logic [15:0] m_in = '0, px_in = {8'd5, 8'd5}, py_in = {8'd1, 8'd1};
  logic [7:0] prime = 8'd17, a_c = 8'd2, b_c = 8'd2;
  logic busy, resp_inf, resp_err, eng_rst, eng_go, eng_done, eng_inf;
  logic [7:0] resp_x, resp_y, eng_m, eng_prime, eng_A, eng_B, eng_Px, eng_Py, eng_Ox, eng_Oy, eng_mGx, eng_mGy;
  int n_chk = 0, n_err = 0, inv_bad = 0, ecnt = 0;
  typedef struct packed {bit inf; int x; int y;} pt_t;
  pt_t eres, gpt;
  ecc_mult_arbiter #(.NUM_REQ(2), .key_size(8), .integer_size(8), .TIMEOUT_CYCLES(16), .DRAIN_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .req(req), .m_in(m_in), .px_in(px_in), .py_in(py_in),
    .prime(prime), .A(a_c), .B(b_c), .grant(grant), .busy(busy), .resp_valid(resp_valid),
    .resp_x(resp_x), .resp_y(resp_y), .resp_inf(resp_inf), .resp_err(resp_err),
    .eng_rst(eng_rst), .eng_go(eng_go), .eng_m(eng_m), .eng_prime(eng_prime), .eng_A(eng_A),
    .eng_B(eng_B), .eng_Px(eng_Px), .eng_Py(eng_Py), .eng_Ox(eng_Ox), .eng_Oy(eng_Oy),
    .eng_done(eng_done), .eng_inf(eng_inf), .eng_mGx(eng_mGx), .eng_mGy(eng_mGy)
  );
  always #5 clk = ~clk;
  function automatic int md(input int a, input int p);
    return ((a % p) + p) % p;
  endfunction
  function automatic int inv(input int a, input int p);
    int r = 1;
    for (int i = 0; i < p - 2; i++) r = md(r * a, p);
    return r;
  endfunction
  function automatic pt_t padd(input pt_t u, input pt_t v, input int ca, input int p);
    pt_t r;
    int l;
    if (u.inf) return v;
    if (v.inf) return u;
    r.inf = 1'b1; r.x = 0; r.y = 0;
    if (u.x == v.x && md(u.y + v.y, p) == 0) return r;
    l = (u.x == v.x) ? md((3 * u.x * u.x + ca) * inv(md(2 * u.y, p), p), p)
                     : md(md(v.y - u.y, p) * inv(md(v.x - u.x, p), p), p);
    r.inf = 1'b0;
    r.x = md(l * l - u.x - v.x, p);
    r.y = md(l * (u.x - r.x) - u.y, p);
    return r;
  endfunction
  function automatic pt_t pmul(input int k, input pt_t g, input int ca, input int p);
    pt_t r;
    r.inf = 1'b1; r.x = 0; r.y = 0;
    for (int i = 7; i >= 0; i--) begin
      r = padd(r, r, ca, p);
      if (k[i]) r = padd(r, g, ca, p);
    end
    return r;
  endfunction
  always_comb begin
    gpt.inf = 1'b0;
    gpt.x = int'(eng_Px);
    gpt.y = int'(eng_Py);
    eres = (eng_prime > 8'd2) ? pmul(int'(eng_m), gpt, int'(eng_A), int'(eng_prime)) : gpt;
  end
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ecnt <= 0; eng_done <= 1'b0; eng_inf <= 1'b0; eng_mGx <= '0; eng_mGy <= '0;
    end else if (eng_rst || !eng_go) begin
      ecnt <= 0; eng_done <= 1'b0;
    end else if (!hang && !eng_done) begin
      if (ecnt == LAT - 1) begin
        eng_done <= 1'b1; eng_inf <= eres.inf; eng_mGx <= 8'(eres.x); eng_mGy <= 8'(eres.y);
      end else ecnt <= ecnt + 1;
    end
  end
  always @(negedge clk) if (rst && (!$onehot0(grant) || !$onehot0(resp_valid) || (eng_go && eng_rst))) inv_bad++;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask
  task automatic wait_grant(output logic [1:0] g);
    g = '0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (grant != 0) begin g = grant; return; end
    end
    chk("grant_timeout", 64'(grant != 0), 1);
  endtask
  task automatic wait_resp(output logic [1:0] rv, output logic [7:0] x, output logic [7:0] y,
                           output logic inf, output logic err, output int n, output int nrst);
    rv = '0; x = '0; y = '0; inf = 1'b0; err = 1'b0; n = 0; nrst = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      n = i;
      if (eng_rst) nrst++;
      if (resp_valid != 0) begin
        rv = resp_valid; x = resp_x; y = resp_y; inf = resp_inf; err = resp_err;
        return;
      end
    end
    chk("resp_timeout", 64'(resp_valid != 0), 1);
  endtask
  logic [1:0] g, rv;
  logic [7:0] rx, ry;
  logic ri, re;
  int n, nrst, pulses;
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outs", {grant, busy, resp_valid, eng_go, eng_rst, resp_x, resp_y, resp_inf, resp_err}, 0);
    rst = 1'b1;
    @(negedge clk);
    m_in = {8'd2, 8'd3};
    req = 2'b11;
    wait_grant(g);
    chk("sim_grant0", g, 2'b01);
    req = 2'b10;
    wait_resp(rv, rx, ry, ri, re, n, nrst);
    chk("sim_rv0", rv, 2'b01);
    chk("sim_x0", rx, 10);
    chk("sim_y0", ry, 6);
    wait_grant(g);
    chk("sim_grant1", g, 2'b10);
    req = 2'b00;
    wait_resp(rv, rx, ry, ri, re, n, nrst);
    chk("sim_rv1", rv, 2'b10);
    chk("sim_xy1", {rx, ry}, {8'd6, 8'd3});
    m_in = {8'd0, 8'd2};
    req = 2'b01;
    wait_grant(g);
    chk("single_grant", g, 2'b01);
    chk("single_ops", {eng_m, eng_Px, eng_Py, eng_prime, eng_A, eng_B}, {8'd2, 8'd5, 8'd1, 8'd17, 8'd2, 8'd2});
    req = 2'b00;
    wait_resp(rv, rx, ry, ri, re, n, nrst);
    chk("single_rv", rv, 2'b01);
    chk("single_xy", {rx, ry}, {8'd6, 8'd3});
    chk("single_inf_err", {ri, re}, 0);
    chk("single_latency", n, LAT + 2);
    @(negedge clk);
    chk("single_pulse_len", resp_valid, 0);
    chk("drain_busy1", busy, 1);
    @(negedge clk);
    chk("drain_busy0", busy, 0);
    m_in = {8'd3, 8'd2};
    req = 2'b01;
    wait_grant(g);
    chk("fair_grant0", g, 2'b01);
    repeat (2) @(negedge clk);
    req = 2'b11;
    wait_resp(rv, rx, ry, ri, re, n, nrst);
    chk("fair_order0", {rv, rx}, {2'b01, 8'd6});
    wait_resp(rv, rx, ry, ri, re, n, nrst);
    chk("fair_order1", {rv, rx}, {2'b10, 8'd10});
    req = 2'b01;
    wait_resp(rv, rx, ry, ri, re, n, nrst);
    chk("fair_order2", {rv, rx}, {2'b01, 8'd6});
    req = 2'b00;
    m_in = {8'd0, 8'd2};
    req = 2'b01;
    wait_grant(g);
    m_in = {8'd3, 8'd3};
    px_in = {8'd6, 8'd6};
    req = 2'b00;
    @(negedge clk);
    chk("latch_ops", {eng_m, eng_Px}, {8'd2, 8'd5});
    wait_resp(rv, rx, ry, ri, re, n, nrst);
    chk("latch_xy", {rx, ry}, {8'd6, 8'd3});
    px_in = {8'd5, 8'd5};
    m_in = {8'd3, 8'd2};
    hang = 1'b1;
    req = 2'b01;
    wait_grant(g);
    chk("to_grant", g, 2'b01);
    req = 2'b00;
    wait_resp(rv, rx, ry, ri, re, n, nrst);
    chk("to_rst_cycles", nrst, 2);
    chk("to_latency", n, 18);
    chk("to_resp", {rv, re, ri, rx, ry}, {2'b01, 1'b1, 1'b0, 8'd0, 8'd0});
    hang = 1'b0;
    req = 2'b10;
    wait_grant(g);
    chk("to_next_grant", g, 2'b10);
    req = 2'b00;
    wait_resp(rv, rx, ry, ri, re, n, nrst);
    chk("to_next_resp", {rv, re, rx, ry}, {2'b10, 1'b0, 8'd10, 8'd6});
    req = 2'b01;
    wait_grant(g);
    req = 2'b00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("arst_outs", {grant, busy, resp_valid, eng_go, eng_rst, resp_x, resp_y, resp_err, eng_m}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (resp_valid != 0) pulses++;
    end
    chk("arst_no_resp", pulses, 0);
    req = 2'b10;
    wait_grant(g);
    chk("arst_grant", g, 2'b10);
    req = 2'b00;
    wait_resp(rv, rx, ry, ri, re, n, nrst);
    chk("arst_resp", {rv, re, rx, ry}, {2'b10, 1'b0, 8'd10, 8'd6});
    chk("invariants", inv_bad, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
